// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// The master requests an operation; the slave (the subtractor) reports
// progress and the registered result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first.
// Timeline for one operation (edge 0 = accepting edge):
//   edge 0        : operands captured, IDLE -> RUN
//   edges 1..WIDTH: one full-subtractor step per edge
//   edge WIDTH    : result published, RUN -> DONE (done high for one cycle)
//   edge WIDTH+1  : DONE -> IDLE, ready to accept again
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;        // minuend, shifted right each RUN cycle
  logic [WIDTH-1:0] b_q;        // subtrahend, shifted right each RUN cycle
  logic             br_q;       // running borrow between bit positions
  logic [WIDTH-1:0] shift_q;    // partial difference, filled from the MSB end
  logic [CNT_W-1:0] cnt_q;      // bits processed so far in this operation
  logic [WIDTH-1:0] diff_q;     // last published result
  logic             borrow_q;   // last published borrow-out
  logic             busy_q;
  logic             done_q;

  logic             d_d;        // difference bit for the current position
  logic             br_d;       // borrow out of the current position
  logic [WIDTH-1:0] shift_d;    // partial difference after this step

  // Full-subtractor step on the current LSBs of the operand registers.
  // NOTE: every signal driven here is assigned unconditionally, so no latch can form.
  always_comb begin
    d_d     = a_q[0] ^ b_q[0] ^ br_q;
    br_d    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    shift_d = {d_d, shift_q[WIDTH-1:1]};
  end

  // Control FSM with datapath registers and registered outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      br_q     <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            br_q    <= bus.bin;
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end

        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          br_q    <= br_d;
          shift_q <= shift_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          // Last bit: publish the fully assembled word straight from the
          // combinational step so the result appears on this same edge.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            diff_q   <= shift_d;
            borrow_q <= br_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_subtractor;

  localparam int W      = 8;
  localparam int PERIOD = 10;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One isolated operation. k counts falling edges after the accepting edge
  // (k = 0 is the first falling edge after edge 0), so done must be seen at
  // k = W and busy must be high for k = 0..W.
  // With repulse set, start is re-pulsed with other operands before edges 3 and 8.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [7:0] exp_d, input logic exp_br,
                       input logic repulse);
    int         lat;
    int         busy_cnt;
    int         done_cnt;
    logic [7:0] prev_d;
    @(negedge clk);
    prev_d    = bus.diff;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.bin   = ~bin;
    lat       = -1;
    busy_cnt  = 0;
    done_cnt  = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.busy) busy_cnt++;
      if (k == 3) check({tag, " diff_hold"}, 32'(bus.diff), 32'(prev_d));
      if (bus.done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = k;
          check({tag, " diff"}, 32'(bus.diff), 32'(exp_d));
          check({tag, " borrow"}, 32'(bus.borrow), 32'(exp_br));
        end
      end
      if (repulse) begin
        if (k == 2 || k == 7) begin
          bus.start = 1'b1;
          bus.a     = 8'hA5 ^ 8'(k);
          bus.b     = 8'h3C;
          bus.bin   = 1'b1;
        end else begin
          bus.start = 1'b0;
        end
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(W));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
    check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
  endtask

  // Reference result: 9-bit subtraction, borrow is the wrap-around bit.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    return {1'b0, a} - {1'b0, b} - {8'd0, bin};
  endfunction

  logic [8:0] exp_q[$];
  logic [8:0] e;
  logic [7:0] ra;
  logic [7:0] rb;
  logic       rbin;
  int         sent;
  int         n_done;
  int         last_done;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    rst       = 1'b0;
    #1 rst    = 1'b1;

    // Reset state, with start asserted to show it is ignored under reset.
    @(negedge clk);
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset diff", 32'(bus.diff), 32'd0);
    check("reset borrow", 32'(bus.borrow), 32'd0);
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check("post-reset idle", 32'(bus.busy), 32'd0);

    // Directed vectors with hand-computed results.
    do_op("v35_12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);
    do_op("v12_35", 8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1'b0);
    do_op("v00_00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    do_op("vFF_FF", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
    do_op("v5A_5A_b", 8'h5A, 8'h5A, 1'b1, 8'hFF, 1'b1, 1'b0);
    do_op("v00_FF", 8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0);
    do_op("v80_01_b", 8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, 1'b0);

    // Start re-pulsed mid-operation must not disturb the run.
    do_op("repulse", 8'h9C, 8'h47, 1'b0, 8'h55, 1'b0, 1'b1);

    // Asynchronous reset during RUN.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h35;
    bus.b     = 8'h12;
    bus.bin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", 32'(bus.busy), 32'd0);
    check("async rst done", 32'(bus.done), 32'd0);
    check("async rst diff", 32'(bus.diff), 32'd0);
    check("async rst borrow", 32'(bus.borrow), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done) n_done++;
      @(negedge clk);
    end
    check("async rst no done", 32'(n_done), 32'd0);
    do_op("after_rst", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);

    // Start held high: back-to-back operations every W+2 cycles.
    // New operands are presented on the falling edge just before each
    // expected accepting edge (every 10 edges after the first).
    @(negedge clk);
    ra        = 8'($urandom);
    rb        = 8'($urandom);
    rbin      = 1'($urandom);
    bus.a     = ra;
    bus.b     = rb;
    bus.bin   = rbin;
    bus.start = 1'b1;
    exp_q.push_back(model(ra, rb, rbin));
    sent      = 1;
    n_done    = 0;
    last_done = -1;
    @(negedge clk);
    for (int t = 0; t < 1000 * (W + 2) + 5; t++) begin
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("b2b spurious done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("b2b diff", 32'(bus.diff), 32'(e[7:0]));
          check("b2b borrow", 32'(bus.borrow), 32'(e[8]));
        end
        if (last_done >= 0) check("b2b spacing", 32'(t - last_done), 32'(W + 2));
        last_done = t;
        n_done++;
      end
      if (t % (W + 2) == W + 1) begin
        if (sent < 1000) begin
          ra      = 8'($urandom);
          rb      = 8'($urandom);
          rbin    = 1'($urandom);
          bus.a   = ra;
          bus.b   = rb;
          bus.bin = rbin;
          exp_q.push_back(model(ra, rb, rbin));
          sent++;
        end else begin
          bus.start = 1'b0;
        end
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("b2b done count", 32'(n_done), 32'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
